// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared widths, FSM state encoding and a block-length helper for the
// ADC block-averaging decimator.
//   DATA_W     : sample width (unsigned)
//   LOG2_N_MAX : largest supported log2(block length)
//   ACC_W      : accumulator width, wide enough for 2^LOG2_N_MAX full-scale samples
//   SUM_W      : accumulator plus one bit, so the rounding add never wraps
//   CNT_W      : sample counter width, holds 0..2^LOG2_N_MAX
//   K_W        : width of the block-length selector
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int DATA_W     = 16;
  localparam int LOG2_N_MAX = 6;
  localparam int ACC_W      = DATA_W + LOG2_N_MAX;
  localparam int SUM_W      = ACC_W + 1;
  localparam int CNT_W      = LOG2_N_MAX + 1;
  localparam int K_W        = 3;

  // One-hot so each state bit can be probed directly on the debug output.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ACCUM = 3'b010,
    ST_DONE  = 3'b100
  } state_t;

  // Block-length selectors above the supported maximum clamp to it.
  function automatic logic [K_W-1:0] sat_k(input logic [K_W-1:0] sel);
    return (sel > K_W'(LOG2_N_MAX)) ? K_W'(LOG2_N_MAX) : sel;
  endfunction

endpackage

// File: rtl/adc_avg_round.sv
// ---------------------------------------------------------------------------
// adc_avg_round
// Combinational round-half-up mean: o_mean = (i_acc + half) >> i_k, where
// half = 2^(i_k-1) for i_k > 0 and 0 for i_k == 0.
//   i_acc  : block sum of 2^i_k unsigned samples
//   i_k    : log2 of the block length (already clamped to LOG2_N_MAX)
//   o_mean : rounded block mean
// The add is done one bit wider than the accumulator. Because the sum of
// 2^k samples is at most 2^k*(2^DATA_W-1), the rounded result always fits
// in DATA_W bits, so the truncation below drops only zero bits.
// ---------------------------------------------------------------------------
module adc_avg_round
  import adc_pkg::*;
(
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [K_W-1:0]    i_k,
  output logic [DATA_W-1:0] o_mean
);

  logic [SUM_W-1:0] w_half;
  logic [SUM_W-1:0] w_sum;

  always_comb begin
    w_half = '0;
    if (i_k != '0) begin
      w_half = SUM_W'(1) << (i_k - K_W'(1));
    end
    w_sum  = {1'b0, i_acc} + w_half;
    o_mean = DATA_W'(w_sum >> i_k);
  end

endmodule

// File: rtl/adc_sample_averager.sv
// ---------------------------------------------------------------------------
// adc_sample_averager
// Block-averaging decimator behind the ADS8860 driver. Accumulates 2^k
// strobed samples, then offers the rounded mean together with the block
// minimum and maximum on a valid/ready output.
//   clk, rst   : single clock, synchronous active-high reset
//   enable     : 0 discards any partial block and holds the FSM in IDLE
//   avg_sel    : k (block length 2^k), clamped to LOG2_N_MAX, latched per block
//   in_data    : sample, qualified by the one-cycle strobe in_valid
//   out_data   : rounded block mean
//   out_min    : smallest sample of the block
//   out_max    : largest sample of the block
//   out_valid  : result present
//   out_ready  : consumer accept
//   overrun    : sticky, a finished block was dropped because the output was full
//   blk_cnt    : samples accumulated in the current block
//   dbg_state  : one-hot FSM state (IDLE/ACCUM/DONE)
//
// Output handshake: a result transfers on every cycle where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_min/out_max do not change. A new result may load in the same
// cycle the previous one is accepted; if the slot is still occupied at load
// time the new result is dropped and overrun is set.
// ---------------------------------------------------------------------------
module adc_sample_averager
  import adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [K_W-1:0]    avg_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [CNT_W-1:0]  blk_cnt,
  output logic [2:0]        dbg_state
);

  state_t            r_state;
  logic [K_W-1:0]    r_k_lat;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_blk_cnt;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_out_min;
  logic [DATA_W-1:0] r_out_max;
  logic              r_out_valid;
  logic              r_overrun;

  logic [K_W-1:0]    w_k_sel;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_blk_len;
  logic [ACC_W-1:0]  w_acc_add;
  logic [DATA_W-1:0] w_min_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic [DATA_W-1:0] w_mean;
  logic              w_out_free;

  assign w_k_sel    = sat_k(avg_sel);
  assign w_cnt_inc  = r_blk_cnt + CNT_W'(1);
  assign w_blk_len  = CNT_W'(1) << r_k_lat;
  assign w_acc_add  = r_acc + ACC_W'(in_data);
  assign w_min_nxt  = (in_data < r_min) ? in_data : r_min;
  assign w_max_nxt  = (in_data > r_max) ? in_data : r_max;
  // Slot is free when empty or being drained on this very edge.
  assign w_out_free = !r_out_valid || out_ready;

  adc_avg_round u_round (
    .i_acc  (r_acc),
    .i_k    (r_k_lat),
    .o_mean (w_mean)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k_lat     <= '0;
      r_acc       <= '0;
      r_blk_cnt   <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_out_data  <= '0;
      r_out_min   <= '0;
      r_out_max   <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Output register: accept first, then a DONE load may refill the slot.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_state == ST_DONE) begin
        if (w_out_free) begin
          r_out_data  <= w_mean;
          r_out_min   <= r_min;
          r_out_max   <= r_max;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun   <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state   <= ST_ACCUM;
            r_k_lat   <= w_k_sel;
            r_acc     <= '0;
            r_blk_cnt <= '0;
            r_min     <= '1;
            r_max     <= '0;
          end
        end

        ST_ACCUM: begin
          if (!enable) begin
            r_state   <= ST_IDLE;
            r_blk_cnt <= '0;
          end else if (in_valid) begin
            r_acc     <= w_acc_add;
            r_blk_cnt <= w_cnt_inc;
            r_min     <= w_min_nxt;
            r_max     <= w_max_nxt;
            if (w_cnt_inc == w_blk_len) begin
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // The finished block is consumed by the output load above; here
          // the next block starts with k re-latched. A sample strobed during
          // DONE becomes the first sample of that new block.
          if (!enable) begin
            r_state   <= ST_IDLE;
            r_blk_cnt <= '0;
          end else begin
            r_k_lat <= w_k_sel;
            if (in_valid) begin
              r_acc     <= ACC_W'(in_data);
              r_blk_cnt <= CNT_W'(1);
              r_min     <= in_data;
              r_max     <= in_data;
              r_state   <= (w_k_sel == '0) ? ST_DONE : ST_ACCUM;
            end else begin
              r_acc     <= '0;
              r_blk_cnt <= '0;
              r_min     <= '1;
              r_max     <= '0;
              r_state   <= ST_ACCUM;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_min   = r_out_min;
  assign out_max   = r_out_max;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign blk_cnt   = r_blk_cnt;
  assign dbg_state = r_state;

endmodule
